// File: rtl/sprite_motion_engine.sv
// Per-frame sprite kinematics: on each qualified frame tick, walks every slot once and
// applies velocity, optional gravity and wrap/bounce edge handling to the active ones.
module sprite_motion_engine #(
   parameter int unsigned NUM_SPRITES = 4,
   parameter int unsigned X_W         = 10,
   parameter int unsigned Y_W         = 9,
   parameter int unsigned V_W         = 8,
   parameter int unsigned SCREEN_W    = 640,
   parameter int unsigned SCREEN_H    = 480,
   parameter int unsigned SPRITE_SIZE = 16,
   parameter int          GRAVITY     = 1,
   parameter int unsigned FRAME_DIV   = 0,
   localparam int unsigned ID_W       = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
   input  logic                         CLOCK_50,
   input  logic                         reset,
   input  logic                         frame_tick,
   input  logic                         cfg_we,
   input  logic [ID_W-1:0]              cfg_id,
   input  logic [X_W-1:0]               cfg_x,
   input  logic [Y_W-1:0]               cfg_y,
   input  logic [V_W-1:0]               cfg_vx,
   input  logic [V_W-1:0]               cfg_vy,
   input  logic [2:0]                   cfg_mode,
   output logic [NUM_SPRITES*X_W-1:0]   pos_x,
   output logic [NUM_SPRITES*Y_W-1:0]   pos_y,
   output logic [NUM_SPRITES-1:0]       active,
   output logic [NUM_SPRITES-1:0]       edge_hit,
   output logic                         busy,
   output logic                         update_done,
   output logic                         overrun
);

   localparam int unsigned XS    = X_W + 2;
   localparam int unsigned YS    = Y_W + 2;
   localparam int unsigned DIV_W = (FRAME_DIV > 0) ? FRAME_DIV : 1;
   localparam logic [ID_W-1:0] LAST = ID_W'(NUM_SPRITES - 1);

   localparam logic signed [XS-1:0] SW_S   = XS'(SCREEN_W);
   localparam logic signed [XS-1:0] XMAX_S = XS'(SCREEN_W - SPRITE_SIZE);
   localparam logic signed [YS-1:0] SH_S   = YS'(SCREEN_H);
   localparam logic signed [YS-1:0] YMAX_S = YS'(SCREEN_H - SPRITE_SIZE);

   localparam logic [V_W-1:0]        VMIN = {1'b1, {(V_W-1){1'b0}}};
   localparam logic [V_W-1:0]        VMAX = {1'b0, {(V_W-1){1'b1}}};
   localparam logic signed [V_W:0]   SMIN = {2'b11, {(V_W-1){1'b0}}};
   localparam logic signed [V_W:0]   SMAX = {2'b00, {(V_W-1){1'b1}}};

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state, next_state;
   logic [ID_W-1:0]    idx;
   logic [DIV_W-1:0]   div_cnt;
   logic               tick_ok, start, over_set;

   logic [X_W-1:0]     x_r    [NUM_SPRITES];
   logic [Y_W-1:0]     y_r    [NUM_SPRITES];
   logic [V_W-1:0]     vx_r   [NUM_SPRITES];
   logic [V_W-1:0]     vy_r   [NUM_SPRITES];
   logic [2:0]         mode_r [NUM_SPRITES];

   logic [X_W-1:0]     new_x;
   logic [Y_W-1:0]     new_y;
   logic [V_W-1:0]     new_vx, new_vy;
   logic               hit_x, hit_y;
   logic signed [XS-1:0] nx;
   logic signed [YS-1:0] ny;

   // Negating the most negative velocity saturates instead of wrapping.
   function automatic logic [V_W-1:0] neg_sat(input logic [V_W-1:0] v);
      return (v == VMIN) ? VMAX : -v;
   endfunction

   function automatic logic [V_W-1:0] grav_sat(input logic [V_W-1:0] v);
      logic signed [V_W:0] s;
      s = (V_W+1)'($signed(v)) + (V_W+1)'(GRAVITY);
      if (s > SMAX)      return VMAX;
      else if (s < SMIN) return VMIN;
      else               return V_W'(s);
   endfunction

   assign tick_ok = frame_tick && ((FRAME_DIV == 0) || (div_cnt == '0));

   always_ff @(posedge CLOCK_50) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      start      = 1'b0;
      over_set   = 1'b0;
      case (state)
         IDLE: if (tick_ok) begin
            next_state = RUN;
            start      = 1'b1;
         end
         RUN: begin
            over_set = tick_ok;
            if (idx == LAST) next_state = DONE;
         end
         DONE: begin
            over_set   = tick_ok;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Kinematic step for the slot currently addressed by idx.
   always_comb begin
      nx     = $signed({2'b00, x_r[idx]}) + XS'($signed(vx_r[idx]));
      ny     = $signed({2'b00, y_r[idx]}) + YS'($signed(vy_r[idx]));
      new_x  = X_W'(nx);
      new_y  = Y_W'(ny);
      new_vx = vx_r[idx];
      new_vy = vy_r[idx];
      hit_x  = 1'b0;
      hit_y  = 1'b0;
      if (!mode_r[idx][2]) begin
         if (nx < 0) begin
            new_x = X_W'(nx + SW_S);
            hit_x = 1'b1;
         end else if (nx >= SW_S) begin
            new_x = X_W'(nx - SW_S);
            hit_x = 1'b1;
         end
         if (ny < 0) begin
            new_y = Y_W'(ny + SH_S);
            hit_y = 1'b1;
         end else if (ny >= SH_S) begin
            new_y = Y_W'(ny - SH_S);
            hit_y = 1'b1;
         end
      end else begin
         if (nx < 0) begin
            new_x  = '0;
            new_vx = neg_sat(vx_r[idx]);
            hit_x  = 1'b1;
         end else if (nx > XMAX_S) begin
            new_x  = X_W'(XMAX_S);
            new_vx = neg_sat(vx_r[idx]);
            hit_x  = 1'b1;
         end
         if (ny < 0) begin
            new_y  = '0;
            new_vy = neg_sat(vy_r[idx]);
            hit_y  = 1'b1;
         end else if (ny > YMAX_S) begin
            new_y  = Y_W'(YMAX_S);
            new_vy = neg_sat(vy_r[idx]);
            hit_y  = 1'b1;
         end
      end
      // A y bounce keeps the negated velocity; gravity waits for the next pass.
      if (mode_r[idx][1] && !(mode_r[idx][2] && hit_y))
         new_vy = grav_sat(vy_r[idx]);
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         idx         <= '0;
         div_cnt     <= '0;
         busy        <= 1'b0;
         update_done <= 1'b0;
         overrun     <= 1'b0;
         edge_hit    <= '0;
         for (int i = 0; i < NUM_SPRITES; i++) begin
            x_r[i]    <= '0;
            y_r[i]    <= '0;
            vx_r[i]   <= '0;
            vy_r[i]   <= '0;
            mode_r[i] <= '0;
         end
      end else begin
         busy        <= (next_state == RUN);
         update_done <= (next_state == DONE);
         if (over_set)   overrun <= 1'b1;
         if (frame_tick) div_cnt <= div_cnt + DIV_W'(1);
         if (start) begin
            idx      <= '0;
            edge_hit <= '0;
         end else if (state == RUN) begin
            idx <= (idx == LAST) ? '0 : idx + ID_W'(1);
         end
         for (int i = 0; i < NUM_SPRITES; i++) begin
            if (cfg_we && (cfg_id == ID_W'(i))) begin
               x_r[i]    <= cfg_x;
               y_r[i]    <= cfg_y;
               vx_r[i]   <= cfg_vx;
               vy_r[i]   <= cfg_vy;
               mode_r[i] <= cfg_mode;
            end else if ((state == RUN) && (idx == ID_W'(i)) && mode_r[i][0]) begin
               x_r[i]      <= new_x;
               y_r[i]      <= new_y;
               vx_r[i]     <= new_vx;
               vy_r[i]     <= new_vy;
               edge_hit[i] <= hit_x | hit_y;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_out
      assign pos_x[g*X_W +: X_W] = x_r[g];
      assign pos_y[g*Y_W +: Y_W] = y_r[g];
      assign active[g]           = mode_r[g][0];
   end

endmodule

// File: tb/tb_sprite_motion_engine.sv
// Directed bench for sprite_motion_engine: vector table for the kinematics plus
// hand-written sequences for timing, overrun, frame division, config collision and reset.
module tb_sprite_motion_engine;

   localparam int NS = 4;
   localparam int XW = 10;
   localparam int YW = 9;
   localparam int VW = 8;

   logic CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   logic            reset, frame_tick, cfg_we;
   logic [1:0]      cfg_id;
   logic [XW-1:0]   cfg_x;
   logic [YW-1:0]   cfg_y;
   logic [VW-1:0]   cfg_vx, cfg_vy;
   logic [2:0]      cfg_mode;
   logic [NS*XW-1:0] pos_x, pos_x2;
   logic [NS*YW-1:0] pos_y, pos_y2;
   logic [NS-1:0]   active, active2, edge_hit, edge_hit2;
   logic            busy, busy2, update_done, update_done2, overrun, overrun2;

   sprite_motion_engine dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .frame_tick(frame_tick), .cfg_we(cfg_we),
      .cfg_id(cfg_id), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_vx(cfg_vx), .cfg_vy(cfg_vy),
      .cfg_mode(cfg_mode), .pos_x(pos_x), .pos_y(pos_y), .active(active),
      .edge_hit(edge_hit), .busy(busy), .update_done(update_done), .overrun(overrun)
   );

   sprite_motion_engine #(.FRAME_DIV(2)) dut2 (
      .CLOCK_50(CLOCK_50), .reset(reset), .frame_tick(frame_tick), .cfg_we(cfg_we),
      .cfg_id(cfg_id), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_vx(cfg_vx), .cfg_vy(cfg_vy),
      .cfg_mode(cfg_mode), .pos_x(pos_x2), .pos_y(pos_y2), .active(active2),
      .edge_hit(edge_hit2), .busy(busy2), .update_done(update_done2), .overrun(overrun2)
   );

   typedef struct {
      bit load;
      int id;
      int x;
      int y;
      int vx;
      int vy;
      int mode;
      int ex;
      int ey;
      int eh;
   } vec_t;

   vec_t vecs[18];
   int checks = 0;
   int passes = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic step();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic cfg_write(input int id, input int x, input int y, input int vx,
                            input int vy, input int mode);
      cfg_id   = 2'(id);
      cfg_x    = XW'(x);
      cfg_y    = YW'(y);
      cfg_vx   = VW'(vx);
      cfg_vy   = VW'(vy);
      cfg_mode = 3'(mode);
      cfg_we   = 1'b1;
      step();
      cfg_we   = 1'b0;
   endtask

   task automatic do_pass();
      bit seen;
      seen = 1'b0;
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         if (update_done) seen = 1'b1;
         else step();
      end
      check("pass_done", int'(seen), 1);
      step();
   endtask

   function automatic int get_x(input int id);
      return int'(pos_x[id*XW +: XW]);
   endfunction

   function automatic int get_y(input int id);
      return int'(pos_y[id*YW +: YW]);
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_pos_x"}, int'(pos_x == '0), 1);
      check({tag, "_pos_y"}, int'(pos_y == '0), 1);
      check({tag, "_active"}, int'(active), 0);
      check({tag, "_edge_hit"}, int'(edge_hit), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_update_done"}, int'(update_done), 0);
      check({tag, "_overrun"}, int'(overrun), 0);
   endtask

   initial begin
      int nb, nd, nd2, nd1;
      reset = 1'b1; frame_tick = 1'b0; cfg_we = 1'b0; cfg_id = '0;
      cfg_x = '0; cfg_y = '0; cfg_vx = '0; cfg_vy = '0; cfg_mode = '0;

      //           load id   x    y   vx   vy  mode  ex   ey  eh
      vecs[0]  = '{1, 0, 620,  50,   8,   0, 5, 624,  50, 1};
      vecs[1]  = '{0, 0,   0,   0,   0,   0, 0, 616,  50, 0};
      vecs[2]  = '{1, 1, 636,  60,   8,   0, 1,   4,  60, 1};
      vecs[3]  = '{1, 1,   3,  60,  -5,   0, 1, 638,  60, 1};
      vecs[4]  = '{1, 2, 200, 100,   0,  -5, 3, 200,  95, 0};
      vecs[5]  = '{0, 2,   0,   0,   0,   0, 0, 200,  91, 0};
      vecs[6]  = '{0, 2,   0,   0,   0,   0, 0, 200,  88, 0};
      vecs[7]  = '{1, 3, 300, 462,   0,   4, 7, 300, 464, 1};
      vecs[8]  = '{0, 3,   0,   0,   0,   0, 0, 300, 460, 0};
      vecs[9]  = '{0, 3,   0,   0,   0,   0, 0, 300, 457, 0};
      vecs[10] = '{1, 2,  10, 100,   0, 127, 3,  10, 227, 0};
      vecs[11] = '{0, 2,   0,   0,   0,   0, 0,  10, 354, 0};
      vecs[12] = '{1, 1,   5,   5,   3,   3, 0,   5,   5, 0};
      vecs[13] = '{1, 0,   0,   2,   0,  -3, 1,   0, 479, 1};
      vecs[14] = '{1, 0,   3,  10,  -5,   0, 5,   0,  10, 1};
      vecs[15] = '{0, 0,   0,   0,   0,   0, 0,   5,  10, 0};
      vecs[16] = '{1, 0, 100,  10,-128,   0, 5,   0,  10, 1};
      vecs[17] = '{0, 0,   0,   0,   0,   0, 0, 127,  10, 0};

      step(); step();
      check_all_zero("reset");
      reset = 1'b0;
      step();

      for (int i = 0; i < 18; i++) begin
         if (vecs[i].load)
            cfg_write(vecs[i].id, vecs[i].x, vecs[i].y, vecs[i].vx, vecs[i].vy, vecs[i].mode);
         do_pass();
         check($sformatf("v%0d_x", i), get_x(vecs[i].id), vecs[i].ex);
         check($sformatf("v%0d_y", i), get_y(vecs[i].id), vecs[i].ey);
         check($sformatf("v%0d_hit", i), int'(edge_hit[vecs[i].id]), vecs[i].eh);
      end

      // Pass timing: busy for NS cycles, a single done pulse.
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
      nb = 0; nd = 0;
      for (int c = 0; c < 12; c++) begin
         if (busy) nb++;
         if (update_done) nd++;
         step();
      end
      check("busy_cycles", nb, NS);
      check("done_pulses", nd, 1);
      check("no_overrun_yet", int'(overrun), 0);

      // Second tick while busy: ignored, overrun latched.
      frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
      nd = 0;
      for (int c = 0; c < 15; c++) begin
         if (update_done) nd++;
         step();
      end
      check("overrun_done_pulses", nd, 1);
      check("overrun_set", int'(overrun), 1);
      step(); step();
      check("overrun_sticky", int'(overrun), 1);

      // cfg write to slot 2 on the cycle slot 2 is processed wins.
      cfg_write(2, 100, 50, 5, 0, 1);
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
      step(); step();
      cfg_id = 2'd2; cfg_x = 10'd333; cfg_y = 9'd222; cfg_vx = 8'd1; cfg_vy = 8'd1;
      cfg_mode = 3'b001; cfg_we = 1'b1;
      step();
      cfg_we = 1'b0;
      for (int c = 0; c < 6; c++) step();
      check("collide_x", get_x(2), 333);
      check("collide_y", get_y(2), 222);
      check("collide_active", int'(active[2]), 1);

      // Frame divider: FRAME_DIV=2 instance runs on every 4th tick only.
      reset = 1'b1; step(); reset = 1'b0; step();
      nd = 0; nd2 = 0; nd1 = 0;
      for (int t = 0; t < 8; t++) begin
         frame_tick = 1'b1; step(); frame_tick = 1'b0;
         for (int c = 0; c < 8; c++) begin
            if (update_done) nd++;
            if (update_done2) nd2++;
            step();
         end
         if (t == 0) nd1 = nd2;
      end
      check("div0_passes", nd, 8);
      check("div2_first_tick", nd1, 1);
      check("div2_passes", nd2, 2);

      // Reset in the middle of a pass, with an overrun pending.
      cfg_write(0, 50, 40, 1, 1, 1);
      frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
      check("pre_reset_busy", int'(busy), 1);
      check("pre_reset_overrun", int'(overrun), 1);
      reset = 1'b1; step();
      check_all_zero("midrun_reset");
      reset = 1'b0; step();
      do_pass();
      check("post_reset_pos_x", int'(pos_x == '0), 1);
      check("post_reset_overrun", int'(overrun), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
